id_ex_pipe: RTL and testbench

ID/EX pipeline register that sits directly downstream of the register file. It captures the two operands (A/B), register indices, immediate and control word for the EX stage. It detects load-use hazards and inserts one-cycle bubbles, honours EX stall and branch flush, and bypasses a same-cycle writeback so EX never sees a stale operand.

---
 rtl/id_ex_pipe_if.sv | 51 +++++
 rtl/id_ex_pipe.sv | 108 ++++++++++
 tb/tb_id_ex_pipe.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/id_ex_pipe_if.sv
// ID/EX pipeline bundle: decode-side operands, writeback bypass inputs,
// EX-side control inputs, and the registered EX-stage outputs.
// master = upstream/downstream environment, slave = the pipeline register.
interface id_ex_pipe_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 9
);
    // Decode stage
    logic              id_valid;
    logic [DATA_W-1:0] id_a;
    logic [DATA_W-1:0] id_b;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic [DATA_W-1:0] id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    // Writeback bypass
    logic              wb_regwrite;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    // Pipeline control
    logic              ex_stall;
    logic              flush;
    logic              id_stall;
    // Execute stage
    logic              ex_valid;
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;
    logic [DATA_W-1:0] ex_imm;
    logic [CTRL_W-1:0] ex_ctrl;

    modport master (
        output id_valid, id_a, id_b, id_rs, id_rt, id_rd, id_imm, id_ctrl,
        output wb_regwrite, wb_rd, wb_data,
        output ex_stall, flush,
        input  id_stall,
        input  ex_valid, ex_a, ex_b, ex_rs, ex_rt, ex_rd, ex_imm, ex_ctrl
    );

    modport slave (
        input  id_valid, id_a, id_b, id_rs, id_rt, id_rd, id_imm, id_ctrl,
        input  wb_regwrite, wb_rd, wb_data,
        input  ex_stall, flush,
        output id_stall,
        output ex_valid, ex_a, ex_b, ex_rs, ex_rt, ex_rd, ex_imm, ex_ctrl
    );
endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with same-cycle writeback bypass, load-use
// bubble insertion, EX stall hold and branch flush.
// Optional macro PIPE_PERF_CNT_EN adds perf_bubbles / perf_flushes counters.
module id_ex_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 9
) (
    input  logic        clk,
    input  logic        rst,
    id_ex_pipe_if.slave bus
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0] perf_bubbles,
    output logic [31:0] perf_flushes
`endif
);
    logic              r_valid;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [REG_AW-1:0] r_rd;
    logic [DATA_W-1:0] r_imm;
    logic [CTRL_W-1:0] r_ctrl;

    logic              w_byp_a;
    logic              w_byp_b;
    logic [DATA_W-1:0] w_a_in;
    logic [DATA_W-1:0] w_b_in;
    logic              w_haz;

    // Bypass a writeback landing this cycle (register file reads are stale);
    // index 0 is hard-wired zero and never bypasses.
    always_comb begin
        w_byp_a = bus.wb_regwrite && (bus.wb_rd != '0) && (bus.wb_rd == bus.id_rs);
        w_byp_b = bus.wb_regwrite && (bus.wb_rd != '0) && (bus.wb_rd == bus.id_rt);
        w_a_in  = w_byp_a ? bus.wb_data : bus.id_a;
        w_b_in  = w_byp_b ? bus.wb_data : bus.id_b;
    end

    // Load in EX whose destination feeds an ID source: needs one bubble
    always_comb begin
        w_haz = r_valid && r_ctrl[1] && (r_rt != '0) && bus.id_valid &&
                ((r_rt == bus.id_rs) || (r_rt == bus.id_rt));
        bus.id_stall = bus.ex_stall || w_haz;
    end

    // Pipeline register: flush > stall > hazard bubble > load > idle bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_rd    <= '0;
            r_imm   <= '0;
            r_ctrl  <= '0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (bus.ex_stall) begin
            r_valid <= r_valid;
        end else if (w_haz || !bus.id_valid) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else begin
            r_valid <= 1'b1;
            r_a     <= w_a_in;
            r_b     <= w_b_in;
            r_rs    <= bus.id_rs;
            r_rt    <= bus.id_rt;
            r_rd    <= bus.id_rd;
            r_imm   <= bus.id_imm;
            r_ctrl  <= bus.id_ctrl;
        end
    end

    assign bus.ex_valid = r_valid;
    assign bus.ex_a     = r_a;
    assign bus.ex_b     = r_b;
    assign bus.ex_rs    = r_rs;
    assign bus.ex_rt    = r_rt;
    assign bus.ex_rd    = r_rd;
    assign bus.ex_imm   = r_imm;
    assign bus.ex_ctrl  = r_ctrl;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_perf_bubbles;
    logic [31:0] r_perf_flushes;

    // Count hazard bubbles and flushes exactly when those update rules win
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_bubbles <= '0;
            r_perf_flushes <= '0;
        end else if (bus.flush) begin
            r_perf_flushes <= r_perf_flushes + 32'd1;
        end else if (!bus.ex_stall && w_haz) begin
            r_perf_bubbles <= r_perf_bubbles + 32'd1;
        end
    end

    assign perf_bubbles = r_perf_bubbles;
    assign perf_flushes = r_perf_flushes;
`endif
endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed testbench for id_ex_pipe: reset, load, bypass, load-use,
// stall/flush priority and (with PIPE_PERF_CNT_EN) the perf counters.
module tb_id_ex_pipe;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    id_ex_pipe_if #(.DATA_W(32), .REG_AW(5), .CTRL_W(9)) bus ();

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_bubbles;
    logic [31:0] perf_flushes;
    id_ex_pipe #(.DATA_W(32), .REG_AW(5), .CTRL_W(9)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes)
    );
`else
    id_ex_pipe #(.DATA_W(32), .REG_AW(5), .CTRL_W(9)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] imm, input logic [8:0] ctrl);
        bus.id_valid = v;  bus.id_a = a;   bus.id_b = b;
        bus.id_rs = rs;    bus.id_rt = rt; bus.id_rd = rd;
        bus.id_imm = imm;  bus.id_ctrl = ctrl;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        set_id(1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 9'h000);
        bus.wb_regwrite = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'h0;
        bus.ex_stall = 1'b0;    bus.flush = 1'b0;
        step();
        step();
        chk("rst_valid", {63'd0, bus.ex_valid}, 64'd0);
        chk("rst_ctrl", {55'd0, bus.ex_ctrl}, 64'd0);
        chk("rst_a", {32'd0, bus.ex_a}, 64'd0);
        chk("rst_stall", {63'd0, bus.id_stall}, 64'd0);
        rst = 1'b0;

        // Normal load
        set_id(1'b1, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3, 32'h10, 9'h001);
        #1 chk("load_idstall", {63'd0, bus.id_stall}, 64'd0);
        step();
        chk("load_valid", {63'd0, bus.ex_valid}, 64'd1);
        chk("load_a", {32'd0, bus.ex_a}, 64'd5);
        chk("load_b", {32'd0, bus.ex_b}, 64'd7);
        chk("load_ctrl", {55'd0, bus.ex_ctrl}, 64'h001);
        chk("load_idx", {49'd0, bus.ex_rs, bus.ex_rt, bus.ex_rd}, {49'd0, 5'd1, 5'd2, 5'd3});
        chk("load_imm", {32'd0, bus.ex_imm}, 64'h10);

        // Writeback bypass onto A
        set_id(1'b1, 32'h0, 32'd7, 5'd3, 5'd2, 5'd4, 32'h0, 9'h001);
        bus.wb_regwrite = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'hDEAD;
        step();
        chk("byp_a", {32'd0, bus.ex_a}, 64'hDEAD);
        chk("byp_a_b", {32'd0, bus.ex_b}, 64'd7);

        // Writeback bypass onto B only
        set_id(1'b1, 32'd11, 32'd22, 5'd1, 5'd5, 5'd4, 32'h0, 9'h001);
        bus.wb_rd = 5'd5; bus.wb_data = 32'hBEEF;
        step();
        chk("byp_b_a", {32'd0, bus.ex_a}, 64'd11);
        chk("byp_b", {32'd0, bus.ex_b}, 64'hBEEF);

        // wb_rd = 0 never bypasses
        set_id(1'b1, 32'h1234, 32'h5678, 5'd0, 5'd0, 5'd4, 32'h0, 9'h001);
        bus.wb_rd = 5'd0; bus.wb_data = 32'hDEAD;
        step();
        chk("byp_r0_a", {32'd0, bus.ex_a}, 64'h1234);
        chk("byp_r0_b", {32'd0, bus.ex_b}, 64'h5678);
        bus.wb_regwrite = 1'b0;

        // Load-use: load writes r4, next instruction reads r4
        set_id(1'b1, 32'h0, 32'h0, 5'd6, 5'd4, 5'd0, 32'h8, 9'h003);
        step();
        chk("lu_load_ctrl", {55'd0, bus.ex_ctrl}, 64'h003);
        set_id(1'b1, 32'h44, 32'h55, 5'd4, 5'd7, 5'd8, 32'h0, 9'h001);
        #1 chk("lu_idstall", {63'd0, bus.id_stall}, 64'd1);
        step();
        chk("lu_bub_valid", {63'd0, bus.ex_valid}, 64'd0);
        chk("lu_bub_ctrl", {55'd0, bus.ex_ctrl}, 64'd0);
        chk("lu_bub_idstall", {63'd0, bus.id_stall}, 64'd0);
        step();
        chk("lu_held_valid", {63'd0, bus.ex_valid}, 64'd1);
        chk("lu_held_a", {32'd0, bus.ex_a}, 64'h44);
        chk("lu_held_ctrl", {55'd0, bus.ex_ctrl}, 64'h001);

        // Load targeting r0 never stalls
        set_id(1'b1, 32'h0, 32'h0, 5'd6, 5'd0, 5'd0, 32'h0, 9'h003);
        step();
        set_id(1'b1, 32'h1, 32'h2, 5'd0, 5'd0, 5'd9, 32'h0, 9'h001);
        #1 chk("lu_r0_idstall", {63'd0, bus.id_stall}, 64'd0);
        step();
        chk("lu_r0_valid", {63'd0, bus.ex_valid}, 64'd1);

        // EX stall: hold for 3 cycles while ID changes
        set_id(1'b1, 32'hA1, 32'hB2, 5'd10, 5'd11, 5'd9, 32'h77, 9'h105);
        step();
        bus.ex_stall = 1'b1;
        set_id(1'b1, 32'hFF, 32'hEE, 5'd12, 5'd13, 5'd14, 32'h99, 9'h0F1);
        #1 chk("stall_idstall", {63'd0, bus.id_stall}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold_valid", {63'd0, bus.ex_valid}, 64'd1);
            chk("stall_hold_a", {32'd0, bus.ex_a}, 64'hA1);
            chk("stall_hold_ctrl", {55'd0, bus.ex_ctrl}, 64'h105);
            chk("stall_hold_rd", {59'd0, bus.ex_rd}, 64'd9);
        end

        // Flush wins over stall; data holds
        bus.flush = 1'b1;
        step();
        chk("flush_valid", {63'd0, bus.ex_valid}, 64'd0);
        chk("flush_ctrl", {55'd0, bus.ex_ctrl}, 64'd0);
        chk("flush_a_hold", {32'd0, bus.ex_a}, 64'hA1);
        bus.flush = 1'b0;
        bus.ex_stall = 1'b0;

        // Hazard coinciding with stall: hold, then bubble, then load
        set_id(1'b1, 32'h0, 32'h0, 5'd6, 5'd4, 5'd0, 32'h0, 9'h003);
        step();
        set_id(1'b1, 32'h66, 32'h0, 5'd4, 5'd4, 5'd8, 32'h0, 9'h001);
        bus.ex_stall = 1'b1;
        step();
        chk("hs_hold_valid", {63'd0, bus.ex_valid}, 64'd1);
        chk("hs_hold_ctrl", {55'd0, bus.ex_ctrl}, 64'h003);
        bus.ex_stall = 1'b0;
        step();
        chk("hs_bub_valid", {63'd0, bus.ex_valid}, 64'd0);
        step();
        chk("hs_load_a", {32'd0, bus.ex_a}, 64'h66);
        chk("hs_load_valid", {63'd0, bus.ex_valid}, 64'd1);

`ifdef PIPE_PERF_CNT_EN
        chk("perf_bubbles", {32'd0, perf_bubbles}, 64'd2);
        chk("perf_flushes", {32'd0, perf_flushes}, 64'd1);
`endif

        // Asynchronous reset mid-cycle with ex_valid=1
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {63'd0, bus.ex_valid}, 64'd0);
        chk("arst_ctrl", {55'd0, bus.ex_ctrl}, 64'd0);
        chk("arst_a", {32'd0, bus.ex_a}, 64'd0);
        chk("arst_idx", {49'd0, bus.ex_rs, bus.ex_rt, bus.ex_rd}, 64'd0);
`ifdef PIPE_PERF_CNT_EN
        chk("arst_perf_b", {32'd0, perf_bubbles}, 64'd0);
        chk("arst_perf_f", {32'd0, perf_flushes}, 64'd0);
`endif
        rst = 1'b0;

        // Idle ID inserts a bubble
        set_id(1'b0, 32'h3, 32'h4, 5'd1, 5'd2, 5'd3, 32'h0, 9'h1FF);
        step();
        chk("idle_valid", {63'd0, bus.ex_valid}, 64'd0);
        chk("idle_ctrl", {55'd0, bus.ex_ctrl}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
